// File: rtl/capture_ctrl.sv
// Capture sequencer for the logic-analyzer RAMqueues: write enable, circular write
// address, pre-trigger arming and post-trigger sample counting.
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wrt_smpl,
  input  logic            run,
  input  logic            capture_done,
  input  logic            triggered,
  input  logic [LOG2-1:0] trig_pos,
  output logic            we,
  output logic [LOG2-1:0] waddr,
  output logic            armed,
  output logic            set_capture_done
);

  localparam int CW = LOG2 + 1;
  localparam logic [CW-1:0]   ENTRIES_C = CW'(ENTRIES);
  localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e          state_q;
  logic [LOG2-1:0] waddr_q;
  logic [CW-1:0]   smpl_cnt_q;
  logic [CW-1:0]   trig_cnt_q;
  logic            trig_seen_q;
  logic            armed_q;
  logic            set_capture_done_q;

  logic [LOG2-1:0] waddr_d;
  logic [CW-1:0]   smpl_cnt_d;
  logic [CW-1:0]   trig_cnt_d;
  logic [CW-1:0]   arm_thresh_s;
  logic [CW-1:0]   trig_target_s;
  logic            trig_qual_s;
  logic            count_trig_s;
  logic            done_hit_s;

  // Post-write counter values and trigger qualification for the current cycle.
  always_comb begin
    waddr_d       = waddr_q;
    smpl_cnt_d    = smpl_cnt_q;
    trig_cnt_d    = trig_cnt_q;
    arm_thresh_s  = ENTRIES_C - {1'b0, trig_pos};
    trig_target_s = {1'b0, trig_pos};
    // armed is the registered value, so a trigger coincident with arming is ignored
    trig_qual_s   = triggered & armed_q;
    count_trig_s  = trig_seen_q | trig_qual_s;
    if (waddr_q == LAST_ADDR) begin
      waddr_d = {LOG2{1'b0}};
    end else begin
      waddr_d = waddr_q + {{(LOG2-1){1'b0}}, 1'b1};
    end
    if (smpl_cnt_q >= ENTRIES_C) begin
      smpl_cnt_d = ENTRIES_C;
    end else begin
      smpl_cnt_d = smpl_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
    if (count_trig_s) begin
      trig_cnt_d = trig_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      trig_cnt_d = trig_cnt_q;
    end
    if (trig_pos == {LOG2{1'b0}}) begin
      trig_target_s = {{(CW-1){1'b0}}, 1'b1};
    end else begin
      trig_target_s = {1'b0, trig_pos};
    end
    done_hit_s = wrt_smpl & count_trig_s & (trig_cnt_d == trig_target_s);
  end

  // Capture FSM with its counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      waddr_q            <= {LOG2{1'b0}};
      smpl_cnt_q         <= {CW{1'b0}};
      trig_cnt_q         <= {CW{1'b0}};
      trig_seen_q        <= 1'b0;
      armed_q            <= 1'b0;
      set_capture_done_q <= 1'b0;
    end else begin
      set_capture_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (run && !capture_done) begin
            state_q     <= CAPTURE;
            waddr_q     <= {LOG2{1'b0}};
            smpl_cnt_q  <= {CW{1'b0}};
            trig_cnt_q  <= {CW{1'b0}};
            trig_seen_q <= 1'b0;
            armed_q     <= 1'b0;
          end
        end
        CAPTURE: begin
          if (wrt_smpl) begin
            waddr_q    <= waddr_d;
            smpl_cnt_q <= smpl_cnt_d;
            trig_cnt_q <= trig_cnt_d;
            if (smpl_cnt_d >= arm_thresh_s) begin
              armed_q <= 1'b1;
            end
          end
          if (trig_qual_s) begin
            trig_seen_q <= 1'b1;
          end
          // abort takes priority over completion: no done pulse when run drops
          if (!run) begin
            state_q <= IDLE;
          end else if (done_hit_s) begin
            state_q            <= FLUSH;
            set_capture_done_q <= 1'b1;
          end
        end
        FLUSH: begin
          state_q <= DONE;
        end
        DONE: begin
          if (!capture_done) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign we               = (state_q == CAPTURE) & wrt_smpl;
  assign waddr            = waddr_q;
  assign armed            = armed_q;
  assign set_capture_done = set_capture_done_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: reset, arming point, wrap, completion, zero
// trigger position, abort and rearm, with hand-computed expectations.
module tb_capture_ctrl;

  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;

  logic            clk;
  logic            rst_n;
  logic            wrt_smpl;
  logic            run;
  logic            capture_done;
  logic            triggered;
  logic [LOG2-1:0] trig_pos;
  logic            we;
  logic [LOG2-1:0] waddr;
  logic            armed;
  logic            set_capture_done;

  int n_checks = 0;
  int n_errors = 0;

  capture_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wrt_smpl         (wrt_smpl),
    .run              (run),
    .capture_done     (capture_done),
    .triggered        (triggered),
    .trig_pos         (trig_pos),
    .we               (we),
    .waddr            (waddr),
    .armed            (armed),
    .set_capture_done (set_capture_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    wrt_smpl     = 1'b0;
    run          = 1'b0;
    capture_done = 1'b0;
    triggered    = 1'b0;
    trig_pos     = 9'd10;
    tick();
    tick();
    check_eq("rst_waddr", 32'(waddr), 32'd0);
    check_eq("rst_armed", 32'(armed), 32'd0);
    check_eq("rst_we", 32'(we), 32'd0);
    check_eq("rst_scd", 32'(set_capture_done), 32'd0);
    rst_n = 1'b1;
    tick();

    // Idle with run low: strobes must not write
    wrt_smpl = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("idle_we_%0d", i), 32'(we), 32'd0);
      tick();
    end

    // Test A: trig_pos=10, trigger on write 500, final write 509
    run = 1'b1;
    @(negedge clk);
    check_eq("a_idle_we", 32'(we), 32'd0);
    tick();
    for (int w = 0; w <= 509; w++) begin
      triggered = (w == 500);
      @(negedge clk);
      check_eq($sformatf("a_we_%0d", w), 32'(we), 32'd1);
      check_eq($sformatf("a_waddr_%0d", w), 32'(waddr), 32'(w % ENTRIES));
      check_eq($sformatf("a_scd_%0d", w), 32'(set_capture_done), 32'd0);
      tick();
      if (w == 372 || w == 373 || w == 383 || w == 509)
        check_eq($sformatf("a_armed_%0d", w), 32'(armed), 32'(w >= 373));
    end
    triggered = 1'b0;
    @(negedge clk);
    check_eq("a_flush_scd", 32'(set_capture_done), 32'd1);
    check_eq("a_flush_we", 32'(we), 32'd0);
    check_eq("a_flush_waddr", 32'(waddr), 32'd126);
    tick();
    capture_done = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq($sformatf("a_done_we_%0d", i), 32'(we), 32'd0);
      check_eq($sformatf("a_done_scd_%0d", i), 32'(set_capture_done), 32'd0);
      check_eq($sformatf("a_done_waddr_%0d", i), 32'(waddr), 32'd126);
      tick();
    end

    // Rearm with trig_pos=0: DONE -> IDLE -> CAPTURE from address 0
    capture_done = 1'b0;
    trig_pos     = 9'd0;
    tick();
    @(negedge clk);
    check_eq("b_idle_we", 32'(we), 32'd0);
    tick();
    // Test B: triggers before arming and on the arming write are ignored
    for (int w = 0; w <= 390; w++) begin
      triggered = (w < 10) || (w == 383) || (w == 390);
      @(negedge clk);
      check_eq($sformatf("b_we_%0d", w), 32'(we), 32'd1);
      check_eq($sformatf("b_waddr_%0d", w), 32'(waddr), 32'(w % ENTRIES));
      check_eq($sformatf("b_scd_%0d", w), 32'(set_capture_done), 32'd0);
      tick();
      if (w == 9 || w == 382 || w == 383)
        check_eq($sformatf("b_armed_%0d", w), 32'(armed), 32'(w >= 383));
    end
    triggered = 1'b0;
    @(negedge clk);
    check_eq("b_flush_scd", 32'(set_capture_done), 32'd1);
    check_eq("b_flush_waddr", 32'(waddr), 32'd7);
    tick();
    capture_done = 1'b1;
    tick();
    capture_done = 1'b0;
    run          = 1'b0;
    tick();

    // Test C: abort mid-capture, then restart at address 0
    trig_pos = 9'd10;
    run      = 1'b1;
    tick();
    for (int w = 0; w < 5; w++) begin
      @(negedge clk);
      check_eq($sformatf("c_waddr_%0d", w), 32'(waddr), 32'(w));
      tick();
    end
    run = 1'b0;
    @(negedge clk);
    check_eq("c_abort_we", 32'(we), 32'd1);
    tick();
    @(negedge clk);
    check_eq("c_aborted_we", 32'(we), 32'd0);
    check_eq("c_aborted_scd", 32'(set_capture_done), 32'd0);
    tick();
    run = 1'b1;
    @(negedge clk);
    check_eq("c_restart_idle_we", 32'(we), 32'd0);
    tick();
    @(negedge clk);
    check_eq("c_restart_waddr", 32'(waddr), 32'd0);
    check_eq("c_restart_we", 32'(we), 32'd1);
    check_eq("c_restart_armed", 32'(armed), 32'd0);
    tick();
    for (int w = 1; w < 8; w++) tick();

    // Test D: asynchronous reset mid-capture
    @(negedge clk);
    check_eq("d_pre_waddr", 32'(waddr), 32'd8);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("d_rst_waddr", 32'(waddr), 32'd0);
    check_eq("d_rst_armed", 32'(armed), 32'd0);
    check_eq("d_rst_we", 32'(we), 32'd0);
    check_eq("d_rst_scd", 32'(set_capture_done), 32'd0);
    tick();
    rst_n    = 1'b1;
    run      = 1'b0;
    wrt_smpl = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
